// File: rtl/psram_pkg.sv
// Shared constants and state encoding for the PSRAM SPI-mode transfer engine.
package psram_pkg;

    localparam int CMD_W       = 8;
    localparam int WIRE_ADDR_W = 24;

    localparam logic [CMD_W-1:0] CMD_READ      = 8'h03;
    localparam logic [CMD_W-1:0] CMD_FAST_READ = 8'h0B;
    localparam logic [CMD_W-1:0] CMD_WRITE     = 8'h02;
    localparam logic [CMD_W-1:0] CMD_RSTEN     = 8'h66;
    localparam logic [CMD_W-1:0] CMD_RST       = 8'h99;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/psram_shift_reg.sv
// Parallel-load, MSB-first shift register with a remaining-bit counter and
// serial-in capture; the low CAP_W bits hold the most recently captured bits.
module psram_shift_reg #(
    parameter int W     = 64,
    parameter int CNT_W = 7,
    parameter int CAP_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             shift,
    input  logic             sin,
    output logic             sout,
    output logic [CNT_W-1:0] count,
    output logic [CAP_W-1:0] capt
);

    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= '0;
            count <= '0;
        end else if (load) begin
            q     <= load_data;
            count <= load_count;
        end else if (shift) begin
            q     <= {q[W-2:0], sin};
            count <= count - 1'b1;
        end
    end

    assign sout = q[W-1];
    assign capt = q[CAP_W-1:0];

endmodule

// File: rtl/psram_spi_xfer.sv
// Single-word SPI-mode read/write engine for the serial PSRAM, SCLK = sys_clk/2.
// Define PSRAM_FAST_READ_EN to issue reads as 0x0B with 8 dummy clocks.
module psram_spi_xfer
    import psram_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int CE_GAP = 4
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              mem_ce,
    output logic              mem_sclk,
    output logic              mem_si,
    input  logic              mem_so
);

`ifdef PSRAM_FAST_READ_EN
    localparam int               DUMMY_W = 8;
    localparam logic [CMD_W-1:0] RD_CMD  = CMD_FAST_READ;
`else
    localparam int               DUMMY_W = 0;
    localparam logic [CMD_W-1:0] RD_CMD  = CMD_READ;
`endif

    localparam int SR_W   = CMD_W + WIRE_ADDR_W + DUMMY_W + DATA_W;
    localparam int WR_N   = CMD_W + WIRE_ADDR_W + DATA_W;
    localparam int CNT_W  = $clog2(SR_W + 1);
    localparam int GAP_W  = $clog2(CE_GAP + 1);

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("psram_spi_xfer: DATA_W must be a multiple of 8");
    end

    logic [WIRE_ADDR_W-1:0] addr24;

    if (ADDR_W >= WIRE_ADDR_W) begin : g_addr_trunc
        assign addr24 = req_addr[WIRE_ADDR_W-1:0];
    end else begin : g_addr_ext
        assign addr24 = {{(WIRE_ADDR_W-ADDR_W){1'b0}}, req_addr};
    end

    state_t            state, state_nxt;
    logic              phase_l;
    logic              is_read;
    logic [GAP_W-1:0]  gap_cnt;
    logic              handshake;
    logic              sr_load, sr_shift, sr_sin, sr_sout;
    logic [SR_W-1:0]   sr_load_data;
    logic [CNT_W-1:0]  sr_load_count;
    logic [CNT_W-1:0]  sr_count;
    logic [DATA_W-1:0] sr_capt;

    assign req_ready = (state == IDLE) && init_done;
    assign handshake = req_valid && req_ready;

    // Frames are left-aligned so the command byte always leaves first.
    assign sr_load_data  = req_we ? (SR_W'({CMD_WRITE, addr24, req_wdata}) << DUMMY_W)
                                  : (SR_W'({RD_CMD, addr24}) << (SR_W - CMD_W - WIRE_ADDR_W));
    assign sr_load_count = req_we ? CNT_W'(WR_N) : CNT_W'(SR_W);

    // Only the trailing DATA_W bits of a read carry data; SO is dropped elsewhere.
    assign sr_sin = is_read && (sr_count <= CNT_W'(DATA_W)) && mem_so;

    psram_shift_reg #(
        .W     (SR_W),
        .CNT_W (CNT_W),
        .CAP_W (DATA_W)
    ) u_shift (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .load       (sr_load),
        .load_data  (sr_load_data),
        .load_count (sr_load_count),
        .shift      (sr_shift),
        .sin        (sr_sin),
        .sout       (sr_sout),
        .count      (sr_count),
        .capt       (sr_capt)
    );

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_l   <= 1'b0;
            is_read   <= 1'b0;
            gap_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            phase_l   <= (state == SHIFT) && !phase_l;
            gap_cnt   <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            rsp_valid <= 1'b0;
            if (sr_load) begin
                is_read <= !req_we;
            end
            if (state == HOLD && is_read) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= sr_capt;
            end
        end
    end

    // Shifting on the edge that ends phase H keeps SI changes inside SCLK-low time.
    always_comb begin
        state_nxt = state;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    sr_load   = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = SHIFT;
            SHIFT: begin
                if (!phase_l) begin
                    sr_shift = 1'b1;
                end else if (sr_count == '0) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: state_nxt = GAP;
            GAP: begin
                if (gap_cnt == GAP_W'(CE_GAP - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign mem_ce   = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
    assign mem_sclk = (state == SHIFT) && !phase_l;
    assign mem_si   = ((state == SETUP) || (state == SHIFT)) && sr_sout;

endmodule

// File: tb/tb_psram_spi_xfer.sv
// Directed self-checking bench for psram_spi_xfer with a minimal PSRAM SO model.
module tb_psram_spi_xfer;

    localparam int DATA_W = 32;
`ifdef PSRAM_FAST_READ_EN
    localparam int         RD_BITS = 72;
    localparam logic [7:0] RD_CMD  = 8'h0B;
`else
    localparam int         RD_BITS = 64;
    localparam logic [7:0] RD_CMD  = 8'h03;
`endif

    logic        sys_clk   = 1'b0;
    logic        rst_n     = 1'b0;
    logic        init_done = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [23:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_so    = 1'b0;
    logic        req_ready, rsp_valid, busy, mem_ce, mem_sclk, mem_si;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    int          ce_low_cnt  = 0;
    int          ce_high_cnt = 0;
    int          last_high   = 0;
    int          edge_cnt    = 0;
    int          rsp_cnt     = 0;
    int          viol        = 0;
    logic [71:0] si_bits     = '0;
    logic        prev_ce     = 1'b1;
    logic        prev_sclk   = 1'b0;
    logic        prev_si     = 1'b0;

    logic [31:0] so_data  = '0;
    int          so_total = 64;
    logic        so_en    = 1'b0;

    always #5 sys_clk = ~sys_clk;

    psram_spi_xfer #(
        .ADDR_W (24),
        .DATA_W (DATA_W),
        .CE_GAP (4)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .mem_ce    (mem_ce),
        .mem_sclk  (mem_sclk),
        .mem_si    (mem_si),
        .mem_so    (mem_so)
    );

    // Bus monitor plus PSRAM read model: SO presents each data bit while SCLK is high.
    always @(negedge sys_clk) begin
        if (!mem_ce && prev_ce) begin
            ce_low_cnt = 0;
            edge_cnt   = 0;
            si_bits    = '0;
            last_high  = ce_high_cnt;
        end
        if (mem_ce && !prev_ce) ce_high_cnt = 0;
        if (mem_ce) begin
            ce_high_cnt++;
            mem_so = 1'b0;
        end else begin
            ce_low_cnt++;
            if (mem_sclk && !prev_sclk) begin
                edge_cnt++;
                si_bits = {si_bits[70:0], mem_si};
                if (so_en && edge_cnt > so_total - DATA_W) mem_so = so_data[so_total - edge_cnt];
                else mem_so = 1'b0;
            end
        end
        if (mem_ce && mem_sclk) viol++;
        if ((mem_si !== prev_si) && mem_sclk) viol++;
        if (rsp_valid) rsp_cnt++;
        prev_ce   = mem_ce;
        prev_sclk = mem_sclk;
        prev_si   = mem_si;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [23:0] addr, input logic [31:0] wd, input bit hold);
        bit acc;
        acc       = 1'b0;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (req_ready) acc = 1'b1;
            tick(1);
        end
        if (!hold) req_valid = 1'b0;
        checkOutput("accept", acc, 1);
    endtask

    task automatic waitDone();
        int i;
        i = 0;
        while (!mem_ce && i < 400) begin
            tick(1);
            i++;
        end
        checkOutput("ce_rise_in_time", mem_ce, 1);
    endtask

    task automatic doRead(input logic [23:0] addr, input logic [31:0] data);
        int          r0;
        logic [71:0] t;
        so_data  = data;
        so_total = RD_BITS;
        so_en    = 1'b1;
        r0       = rsp_cnt;
        applyStimulus(1'b0, addr, 32'h0, 1'b0);
        waitDone();
        checkOutput("rd_ce_low_cycles", ce_low_cnt, 2 * RD_BITS + 2);
        checkOutput("rd_sclk_edges", edge_cnt, RD_BITS);
        t = si_bits >> (RD_BITS - 32);
        checkOutput("rd_si_cmd_addr", t[31:0], {RD_CMD, addr});
        t = si_bits & ((72'd1 << (RD_BITS - 32)) - 72'd1);
        checkOutput("rd_si_tail_zero", t, 0);
        checkOutput("rd_rsp_valid", rsp_valid, 1);
        checkOutput("rd_rdata", rsp_rdata, data);
        tick(1);
        checkOutput("rd_rsp_pulse_end", rsp_valid, 0);
        checkOutput("rd_rsp_count", rsp_cnt - r0, 1);
        so_en = 1'b0;
    endtask

    initial begin
        int r0, d, i;

        tick(3);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_mem_ce", mem_ce, 1);
        checkOutput("rst_mem_sclk", mem_sclk, 0);
        checkOutput("rst_mem_si", mem_si, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);

        rst_n = 1'b1;
        req_we = 1'b1;
        req_valid = 1'b1;
        tick(3);
        checkOutput("gated_req_ready", req_ready, 0);
        checkOutput("gated_no_accept", busy, 0);
        req_valid = 1'b0;
        init_done = 1'b1;
        tick(1);
        checkOutput("init_req_ready", req_ready, 1);

        $display("[TB] write 0x000123 <- 0xDEADBEEF");
        r0 = rsp_cnt;
        applyStimulus(1'b1, 24'h000123, 32'hDEADBEEF, 1'b0);
        checkOutput("wr_busy", busy, 1);
        checkOutput("wr_ready_low", req_ready, 0);
        waitDone();
        checkOutput("wr_ce_low_cycles", ce_low_cnt, 130);
        checkOutput("wr_sclk_edges", edge_cnt, 64);
        checkOutput("wr_si_stream", si_bits[63:0], 64'h02000123DEADBEEF);
        checkOutput("wr_no_rsp_valid", rsp_valid, 0);
        tick(2);
        checkOutput("wr_rsp_count", rsp_cnt - r0, 0);

        $display("[TB] read 0x00ABCD");
        doRead(24'h00ABCD, 32'hCAFEF00D);

        $display("[TB] back-to-back writes");
        applyStimulus(1'b1, 24'h000456, 32'h01234567, 1'b1);
        waitDone();
        d = 0;
        while (!req_ready && d < 20) begin
            tick(1);
            d++;
        end
        checkOutput("b2b_accept_delay", d, 4);
        tick(1);
        req_valid = 1'b0;
        checkOutput("b2b_second_busy", busy, 1);
        waitDone();
        checkOutput("b2b_ce_high_ge4", last_high >= 4, 1);
        checkOutput("b2b_ce_low_cycles", ce_low_cnt, 130);
        checkOutput("b2b_si_stream", si_bits[63:0], 64'h0200045601234567);
        checkOutput("rdata_held", rsp_rdata, 32'hCAFEF00D);

        $display("[TB] reset during write");
        applyStimulus(1'b1, 24'h000789, 32'hA5A5A5A5, 1'b0);
        i = 0;
        while (edge_cnt < 20 && i < 100) begin
            tick(1);
            i++;
        end
        checkOutput("edge20_reached", edge_cnt, 20);
        r0 = rsp_cnt;
        rst_n = 1'b0;
        tick(1);
        checkOutput("abort_mem_ce", mem_ce, 1);
        checkOutput("abort_mem_sclk", mem_sclk, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        tick(3);
        checkOutput("abort_no_rsp", rsp_cnt - r0, 0);

        $display("[TB] read 0x000010 after abort");
        doRead(24'h000010, 32'h12345678);

        tick(6);
        checkOutput("protocol_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
